// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that issues one op per cycle from two requesters to a registered ALU,
// and routes each result back to its issuer through a tag pipeline matched to ALU latency.
module alu_rr_arbiter #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req0_sel,
  input  logic [3:0] req1_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_y,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp0_y,
  output logic [7:0] rsp1_y,
  output logic       busy
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  prio_e            r_prio;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [3:0]       r_alu_sel;
  logic [ALU_LAT:0] r_tag_vld;
  logic [ALU_LAT:0] r_tag_id;

  logic w_gnt0;
  logic w_gnt1;
  logic w_xfer;

  // The pointer only breaks ties; a lone valid requester is always served.
  always_comb begin
    w_gnt0 = en & req0_valid & (~req1_valid | (r_prio == PRIO_REQ0));
    w_gnt1 = en & req1_valid & (~req0_valid | (r_prio == PRIO_REQ1));
    w_xfer = w_gnt0 | w_gnt1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio    <= PRIO_REQ0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      if (w_xfer) begin
        r_prio    <= w_gnt1 ? PRIO_REQ0 : PRIO_REQ1;
        r_alu_a   <= w_gnt1 ? req1_a   : req0_a;
        r_alu_b   <= w_gnt1 ? req1_b   : req0_b;
        r_alu_sel <= w_gnt1 ? req1_sel : req0_sel;
      end
      r_tag_vld[0] <= w_xfer;
      r_tag_id[0]  <= w_gnt1;
      for (int unsigned i = 1; i <= ALU_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp0_valid = r_tag_vld[ALU_LAT] & ~r_tag_id[ALU_LAT];
  assign rsp1_valid = r_tag_vld[ALU_LAT] &  r_tag_id[ALU_LAT];
  assign rsp0_y     = alu_y;
  assign rsp1_y     = alu_y;
  assign busy       = |r_tag_vld;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a two-stage registered ALU stand-in, a per-cycle vector table,
// and a hand-written mid-flight reset sequence.
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_y;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_y, rsp1_y;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_rr_arbiter #(.ALU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_y(rsp0_y), .rsp1_y(rsp1_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in: registers inputs, then registers the result (latency 2).
  logic [3:0]        m_a, m_b, m_sel;
  logic signed [7:0] m_ea, m_eb;
  always_comb begin
    m_ea = {{4{m_a[3]}}, m_a};
    m_eb = {{4{m_b[3]}}, m_b};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_sel <= '0; alu_y <= '0;
    end else begin
      m_a <= alu_a; m_b <= alu_b; m_sel <= alu_sel;
      case (m_sel)
        4'b0000: alu_y <= m_ea + 8'sd1;
        4'b0101: alu_y <= m_ea * m_eb;
        4'b0110: alu_y <= m_ea + m_eb;
        4'b0111: alu_y <= m_ea - m_eb;
        default: alu_y <= '0;
      endcase
    end
  end

  typedef struct {
    logic       en;
    logic       v0;
    logic [3:0] a0, b0, s0;
    logic       v1;
    logic [3:0] a1, b1, s1;
    logic       er0, er1, ev0, ev1;
    logic [7:0] ey;
    logic       ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic v0, input logic [3:0] a0, b0, s0,
                              input logic v1, input logic [3:0] a1, b1, s1,
                              input logic er0, er1, ev0, ev1, input logic [7:0] ey,
                              input logic eb);
    vec_t v;
    v.en = e; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
    v.er0 = er0; v.er1 = er1; v.ev0 = ev0; v.ev1 = ev1; v.ey = ey; v.ebusy = eb;
    return v;
  endfunction

  function automatic vec_t idle(input logic ev0, ev1, input logic [7:0] ey, input logic eb);
    return mk(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,
              1'b0, 1'b0, ev0, ev1, ey, eb);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v0, input logic [3:0] a0, b0, s0,
                       input logic v1, input logic [3:0] a1, b1, s1);
    en = e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] iv;
    // Single add from req0.
    tbl.push_back(mk(1'b1, 1'b1, 4'd3, 4'd2, 4'b0110, 1'b0, 4'd0, 4'd0, 4'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(idle(1'b1, 1'b0, 8'h05, 1'b1));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b0));
    // req1 signed multiply then subtract, back to back.
    tbl.push_back(mk(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'hD, 4'd4, 4'b0101,
                     1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd7, 4'b0111,
                     1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(idle(1'b0, 1'b1, 8'hF4, 1'b1));
    tbl.push_back(idle(1'b0, 1'b1, 8'hFE, 1'b1));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b0));
    // Contention for 8 cycles: prio is 0, so req0 first, then strict alternation.
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b1, 1'b1, 4'd1, 4'd1, 4'b0110, 1'b1, 4'd2, 4'd2, 4'b0110,
                       (i % 2) == 0, (i % 2) == 1,
                       (i >= 3) && ((i % 2) == 1), (i >= 3) && ((i % 2) == 0),
                       (i < 3) ? 8'h00 : (((i % 2) == 1) ? 8'h02 : 8'h04), i != 0));
    end
    tbl.push_back(idle(1'b0, 1'b1, 8'h04, 1'b1));
    tbl.push_back(idle(1'b1, 1'b0, 8'h02, 1'b1));
    tbl.push_back(idle(1'b0, 1'b1, 8'h04, 1'b1));
    // req0 streams increments of 0..5.
    for (int i = 0; i < 6; i++) begin
      iv = i[3:0];
      tbl.push_back(mk(1'b1, 1'b1, iv, 4'd0, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0,
                       1'b1, 1'b0, i >= 3, 1'b0, (i >= 3) ? {4'd0, iv} - 8'd2 : 8'h00, i != 0));
    end
    // en low with both valid; the stream tail (4,5,6) still drains.
    for (int i = 0; i < 4; i++) begin
      iv = i[3:0];
      tbl.push_back(mk(1'b0, 1'b1, 4'd1, 4'd1, 4'b0110, 1'b1, 4'd2, 4'd2, 4'b0110,
                       1'b0, 1'b0, i < 3, 1'b0, (i < 3) ? 8'd4 + {4'd0, iv} : 8'h00, i < 3));
    end
    // prio held at 1 through en=0, so req1 wins the tie.
    tbl.push_back(mk(1'b1, 1'b1, 4'd1, 4'd1, 4'b0110, 1'b1, 4'd2, 4'd2, 4'b0110,
                     1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(idle(1'b0, 1'b1, 8'h04, 1'b1));
    tbl.push_back(idle(1'b0, 1'b0, 8'h00, 1'b0));

    drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("reset_ready", {6'd0, req1_ready, req0_ready}, 8'h00);
    chk("reset_alu_a", {4'd0, alu_a}, 8'h00);
    chk("reset_alu_b", {4'd0, alu_b}, 8'h00);
    chk("reset_alu_sel", {4'd0, alu_sel}, 8'h00);
    chk("reset_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    next_cycle();
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].en, tbl[r].v0, tbl[r].a0, tbl[r].b0, tbl[r].s0,
            tbl[r].v1, tbl[r].a1, tbl[r].b1, tbl[r].s1);
      @(negedge clk);
      chk($sformatf("row%0d_ready", r), {6'd0, req1_ready, req0_ready},
          {6'd0, tbl[r].er1, tbl[r].er0});
      chk($sformatf("row%0d_rsp_valid", r), {6'd0, rsp1_valid, rsp0_valid},
          {6'd0, tbl[r].ev1, tbl[r].ev0});
      chk($sformatf("row%0d_busy", r), {7'd0, busy}, {7'd0, tbl[r].ebusy});
      if (tbl[r].ev0) chk($sformatf("row%0d_rsp0_y", r), rsp0_y, tbl[r].ey);
      if (tbl[r].ev1) chk($sformatf("row%0d_rsp1_y", r), rsp1_y, tbl[r].ey);
      next_cycle();
    end

    // Mid-flight reset: two req0 ops leave prio=1, then reset discards them.
    drive(1'b1, 1'b1, 4'd3, 4'd2, 4'b0110, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("mf_issue0_ready", {6'd0, req1_ready, req0_ready}, 8'h01);
    next_cycle();
    drive(1'b1, 1'b1, 4'd1, 4'd1, 4'b0110, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("mf_issue1_ready", {6'd0, req1_ready, req0_ready}, 8'h01);
    next_cycle();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("mf_busy_before_reset", {7'd0, busy}, 8'h01);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mf_reset_busy", {7'd0, busy}, 8'h00);
    chk("mf_reset_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'h00);
    chk("mf_reset_alu_a", {4'd0, alu_a}, 8'h00);
    chk("mf_reset_alu_b", {4'd0, alu_b}, 8'h00);
    chk("mf_reset_alu_sel", {4'd0, alu_sel}, 8'h00);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mf_quiet%0d_rsp_valid", i), {6'd0, rsp1_valid, rsp0_valid}, 8'h00);
      next_cycle();
    end
    // Both valid after reset: prio must be back at req0.
    drive(1'b1, 1'b1, 4'd7, 4'd1, 4'b0110, 1'b1, 4'd2, 4'd2, 4'b0110);
    @(negedge clk);
    chk("post_ready0", {6'd0, req1_ready, req0_ready}, 8'h01);
    next_cycle();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd2, 4'b0110);
    @(negedge clk);
    chk("post_ready1", {6'd0, req1_ready, req0_ready}, 8'h02);
    chk("post_alu_a", {4'd0, alu_a}, 8'h07);
    chk("post_alu_b", {4'd0, alu_b}, 8'h01);
    chk("post_alu_sel", {4'd0, alu_sel}, 8'h06);
    next_cycle();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("post_c2_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'h00);
    chk("post_c2_busy", {7'd0, busy}, 8'h01);
    next_cycle();
    @(negedge clk);
    chk("post_c3_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'h01);
    chk("post_c3_rsp0_y", rsp0_y, 8'h08);
    next_cycle();
    @(negedge clk);
    chk("post_c4_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'h02);
    chk("post_c4_rsp1_y", rsp1_y, 8'h04);
    next_cycle();
    @(negedge clk);
    chk("post_c5_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'h00);
    chk("post_c5_busy", {7'd0, busy}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and issue controller that shares the single registered 4-bit signed ALU between two independent requesters. It accepts one operation per cycle through valid/ready handshakes and drives the ALU operand and select inputs from flops. It tracks each in-flight operation with a tag pipeline matched to the ALU latency, and returns each 8-bit result to the requester that issued it. It sits directly in front of the ALU, on the same clk/rst_n.

## Interface
- ALU_LAT, 2: ALU latency in cycles, from its inputs being driven to its y output updating. The ALU registers its inputs and then its output.
- clk  in  1  system clock; all flops rise-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  issue enable; when low, no new request is accepted, but in-flight operations still drain.
- req0_valid, req1_valid  in  1  requester n presents an operation.
- req0_ready, req1_ready  out  1  request n accepted this cycle (combinational grant).
- req0_a, req0_b, req1_a, req1_b  in  4  signed operands.
- req0_sel, req1_sel  in  4  ALU opcode, passed through unchanged.
- alu_a, alu_b  out  4  registered operands to the ALU.
- alu_sel  out  4  registered opcode to the ALU.
- alu_y  in  8  signed ALU result.
- rsp0_valid, rsp1_valid  out  1  registered; one-cycle pulse per completed operation of requester n.
- rsp0_y, rsp1_y  out  8  equal to alu_y, combinationally; meaningful only while the matching rsp valid is high.
- busy  out  1  high while any tag stage holds a valid entry.

## Operation
- Transfer rule: a transfer occurs on req_n when req_n_valid and req_n_ready are both high at a clk edge. A requester must hold valid and its operands stable until ready is seen.
- Grant (combinational):
  - At most one ready per cycle.
  - No ready while en=0.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester named by the priority pointer `prio` is granted.
- Pointer update: `prio` is 1 bit, reset value 0 (req0 favoured). After any transfer it points to the requester that was not granted. With no transfer it is unchanged.
- Issue: on a transfer, alu_a, alu_b and alu_sel load the granted requester's a, b and sel at that edge. With no transfer they hold their previous values; the ALU result is then ignored.
- Tag pipeline:
  - ALU_LAT+1 stages, each holding {valid, id}.
  - Stage 0 loads {transfer, granted id} every edge; every other stage shifts forward every edge.
  - The last stage drives rsp0_valid (when id=0) or rsp1_valid (when id=1).
- Throughput and ordering: one operation per cycle sustained, with no bubbles. Responses return in issue order. No response backpressure exists; requesters must always sink responses.
- Arithmetic: the arbiter never modifies data. Result semantics come from the ALU, as 8-bit signed values (for example add, sub, multiply, and logic ops on sign-extended operands).
- Reset values: req ready 0 (en-gated), alu_a/alu_b/alu_sel 0, prio 0, all tag stages invalid, rsp valids 0, busy 0.

## Timing
- Latency: a transfer at edge k puts operands on alu_* after edge k. The ALU captures them at k+1 and updates y at k+2. rspN_valid is high for exactly the cycle between edges k+ALU_LAT and k+ALU_LAT+1, i.e. 3 cycles after acceptance with default ALU_LAT.
- Back-to-back: transfers at consecutive edges give responses on consecutive cycles.
- Simultaneous events:
  - Both requesters valid for N cycles: grants alternate every cycle, starting from prio.
  - A transfer while responses are completing has no interaction.
- en deasserted mid-stream: the issue stops the same cycle. Already-issued operations still respond on schedule. busy falls the cycle after the last response.
- Reset mid-operation: all tag stages are cleared asynchronously, so in-flight results are discarded and no rsp pulses follow. The ALU is reset by the same rst_n.
- After rst_n deasserts, the first transfer is possible at the first clk edge.

## Test plan
- Single add: req0 a=3, b=2, sel=0110 at edge T -> req0_ready=1 at T; rsp0_valid only in cycle T+3 with rsp0_y=8'h05; rsp1_valid stays 0.
- Signed multiply and subtract: req1 a=-3, b=4, sel=0101, then a=5, b=7, sel=0111 on consecutive edges -> rsp1_y=8'hF4, then 8'hFE, on consecutive cycles.
- Contention: both requesters valid from reset with add ops (req0 1+1, req1 2+2) -> req0 granted first, req1 next; rsp0_y=8'h02 at T+3, rsp1_y=8'h04 at T+4; then strict alternation for 6 further cycles.
- Single requester streaming: req0 issues increment a=0..5 (sel=0000) on 6 consecutive edges -> ready held high; rsp0_y=1..6 on 6 consecutive cycles, in order.
- en gating: en=0 with both requesters valid for 4 cycles -> no ready; busy falls after in-flight responses drain; prio unchanged.
- Reset mid-flight: issue 2 ops, assert rst_n low 1 cycle later -> no rsp pulses; all outputs 0; the next add (7+1) returns 8'h08 three cycles after acceptance.
